// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM encoding, NOP word and instruction bit-field positions.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam int unsigned OP_LSB = 0;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_LSB = 12;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_LSB = 25;
    localparam int unsigned F7_W   = 7;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetchState_t;

    function automatic logic [OP_W-1:0] instrOp(input logic [XLEN-1:0] word);
        return word[OP_LSB +: OP_W];
    endfunction

    function automatic logic [F3_W-1:0] instrF3(input logic [XLEN-1:0] word);
        return word[F3_LSB +: F3_W];
    endfunction

    function automatic logic [F7_W-1:0] instrF7(input logic [XLEN-1:0] word);
        return word[F7_LSB +: F7_W];
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential pc+4 or control-selected target, with word-alignment check.
module pc_next
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] pcTarget,
    output logic [XLEN-1:0] nextPc,
    output logic [XLEN-1:0] pcPlus4,
    output logic            misaligned
);

    always_comb begin
        pcPlus4    = pc + XLEN'(4);
        nextPc     = pcSrc ? pcTarget : pcPlus4;
        misaligned = (nextPc[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and holds
// the current instruction for the control unit until the datapath retires it.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemReady,
    input  logic [XLEN-1:0] imemRdata,
    input  logic            advance,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] pcTarget,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic [XLEN-1:0] instr,
    output logic [OP_W-1:0] op,
    output logic [F3_W-1:0] f3,
    output logic [F7_W-1:0] f7,
    output logic            instrValid,
    output logic            busErr,
    output logic            misalignErr,
    output logic [XLEN-1:0] fetchCount
);

    localparam int unsigned CNT_W = 8;

    fetchState_t      state, stateNext;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic [XLEN-1:0]  pcNext, instrNext, fetchCountNext;
    logic             imemReqNext, instrValidNext, busErrNext, misalignErrNext;
    logic [XLEN-1:0]  candPc;
    logic             candMisaligned;

    pc_next uPcNext (
        .pc         (pc),
        .pcSrc      (pcSrc),
        .pcTarget   (pcTarget),
        .nextPc     (candPc),
        .pcPlus4    (pcPlus4),
        .misaligned (candMisaligned)
    );

    assign imemAddr = pc;
    assign op       = instrOp(instr);
    assign f3       = instrF3(instr);
    assign f7       = instrF7(instr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RESET;
            waitCnt     <= '0;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            imemReq     <= 1'b0;
            instrValid  <= 1'b0;
            busErr      <= 1'b0;
            misalignErr <= 1'b0;
            fetchCount  <= '0;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            pc          <= pcNext;
            instr       <= instrNext;
            imemReq     <= imemReqNext;
            instrValid  <= instrValidNext;
            busErr      <= busErrNext;
            misalignErr <= misalignErrNext;
            fetchCount  <= fetchCountNext;
        end
    end

    always_comb begin
        stateNext       = state;
        waitCntNext     = waitCnt;
        pcNext          = pc;
        instrNext       = instr;
        busErrNext      = busErr;
        misalignErrNext = misalignErr;
        fetchCountNext  = fetchCount;

        case (state)
            S_RESET: stateNext = S_REQ;
            S_REQ: begin
                if (imemReady) begin
                    instrNext   = imemRdata;
                    waitCntNext = '0;
                    stateNext   = S_HOLD;
                end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    waitCntNext = waitCnt + CNT_W'(1);
                    busErrNext  = 1'b1;
                    stateNext   = S_HALT;
                end else begin
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // An accepted advance retires the instruction even if the new PC traps.
                if (advance) begin
                    fetchCountNext = fetchCount + XLEN'(1);
                    if (candMisaligned) begin
                        misalignErrNext = 1'b1;
                        stateNext       = S_HALT;
                    end else begin
                        pcNext    = candPc;
                        stateNext = S_REQ;
                    end
                end
            end
            S_HALT: stateNext = S_HALT;
            default: stateNext = S_HALT;
        endcase

        // Handshake flags are registered copies of the state being entered.
        imemReqNext    = (stateNext == S_REQ);
        instrValidNext = (stateNext == S_HOLD);
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized transaction-level bench for fetch_stage against a behavioural PC/fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, resetB;
    logic        imemReady, advance, pcSrc;
    logic [31:0] imemRdata, pcTarget;

    logic        imemReq, instrValid, busErr, misalignErr;
    logic [31:0] imemAddr, pc, pcPlus4, instr, fetchCount;
    logic [6:0]  op, f7;
    logic [2:0]  f3;

    logic        imemReqB, instrValidB, busErrB, misalignErrB;
    logic [31:0] imemAddrB, pcB, pcPlus4B, instrB, fetchCountB;
    logic [6:0]  opB, f7B;
    logic [2:0]  f3B;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] expPc, expCount, lastWord;
    bit          halted;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemRdata(imemRdata), .advance(advance),
        .pcSrc(pcSrc), .pcTarget(pcTarget), .pc(pc), .pcPlus4(pcPlus4),
        .instr(instr), .op(op), .f3(f3), .f7(f7), .instrValid(instrValid),
        .busErr(busErr), .misalignErr(misalignErr), .fetchCount(fetchCount)
    );

    fetch_stage #(.RESET_PC(32'h8000_0000), .TIMEOUT(255)) dutB (
        .clk(clk), .reset(resetB), .imemReq(imemReqB), .imemAddr(imemAddrB),
        .imemReady(imemReady), .imemRdata(imemRdata), .advance(advance),
        .pcSrc(pcSrc), .pcTarget(pcTarget), .pc(pcB), .pcPlus4(pcPlus4B),
        .instr(instrB), .op(opB), .f3(f3B), .f7(f7B), .instrValid(instrValidB),
        .busErr(busErrB), .misalignErr(misalignErrB), .fetchCount(fetchCountB)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory answers after waitCyc idle request cycles; then the word must be held.
    task automatic doFetch(input int waitCyc);
        logic [31:0] word;
        for (int i = 0; i < waitCyc; i++) begin
            checkVal("waitReq", 32'(imemReq), 32'd1);
            checkVal("waitAddr", imemAddr, expPc);
            checkVal("waitValid", 32'(instrValid), 32'd0);
            imemReady = 1'b0;
            imemRdata = $urandom;
            @(negedge clk);
        end
        checkVal("reqHigh", 32'(imemReq), 32'd1);
        checkVal("reqAddr", imemAddr, expPc);
        word      = $urandom;
        imemReady = 1'b1;
        imemRdata = word;
        @(negedge clk);
        imemReady = 1'b0;
        imemRdata = $urandom;
        lastWord  = word;
        checkVal("holdValid", 32'(instrValid), 32'd1);
        checkVal("holdInstr", instr, word);
        checkVal("holdOp", 32'(op), 32'(word[6:0]));
        checkVal("holdF3", 32'(f3), 32'(word[14:12]));
        checkVal("holdF7", 32'(f7), 32'(word[31:25]));
        checkVal("holdPc", pc, expPc);
        checkVal("holdPcPlus4", pcPlus4, expPc + 32'd4);
        checkVal("holdReqLow", 32'(imemReq), 32'd0);
        checkVal("holdBusErr", 32'(busErr), 32'd0);
    endtask

    // Stall holdCyc cycles with noise on ignored inputs, then retire with the given redirect.
    task automatic doAdvance(input int holdCyc, input bit src, input logic [31:0] tgt);
        logic [31:0] nxt;
        for (int i = 0; i < holdCyc; i++) begin
            advance   = 1'b0;
            pcSrc     = 1'($urandom);
            pcTarget  = $urandom;
            imemReady = 1'($urandom);
            imemRdata = $urandom;
            @(negedge clk);
            checkVal("stallValid", 32'(instrValid), 32'd1);
            checkVal("stallInstr", instr, lastWord);
            checkVal("stallReq", 32'(imemReq), 32'd0);
        end
        advance   = 1'b1;
        pcSrc     = src;
        pcTarget  = tgt;
        imemReady = 1'($urandom);
        nxt       = src ? tgt : expPc + 32'd4;
        expCount  = expCount + 32'd1;
        @(negedge clk);
        advance   = 1'b0;
        imemReady = 1'b0;
        checkVal("advCount", fetchCount, expCount);
        if (nxt[1:0] != 2'b00) begin
            halted = 1'b1;
            checkVal("misErr", 32'(misalignErr), 32'd1);
            checkVal("misPc", pc, expPc);
            checkVal("misValid", 32'(instrValid), 32'd0);
            checkVal("misReq", 32'(imemReq), 32'd0);
        end else begin
            expPc = nxt;
            checkVal("advReq", 32'(imemReq), 32'd1);
            checkVal("advAddr", imemAddr, expPc);
            checkVal("advValid", 32'(instrValid), 32'd0);
            checkVal("advMisErr", 32'(misalignErr), 32'd0);
        end
    endtask

    task automatic resetMain();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        expPc    = 32'h0;
        expCount = 32'h0;
        halted   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; resetB = 1'b1;
        imemReady = 1'b0; advance = 1'b0; pcSrc = 1'b0;
        imemRdata = 32'h0; pcTarget = 32'h0;
        expPc = 32'h0; expCount = 32'h0; lastWord = 32'h0; halted = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkVal("rstPc", pc, 32'h0);
        checkVal("rstInstr", instr, 32'h0000_0013);
        checkVal("rstOp", 32'(op), 32'h13);
        checkVal("rstValid", 32'(instrValid), 32'd0);
        checkVal("rstReq", 32'(imemReq), 32'd0);
        checkVal("rstBusErr", 32'(busErr), 32'd0);
        checkVal("rstMisErr", 32'(misalignErr), 32'd0);
        checkVal("rstCount", fetchCount, 32'd0);

        reset = 1'b0;
        @(negedge clk);

        // Sequential zero-wait fetches.
        for (int i = 0; i < 3; i++) begin
            doFetch(0);
            doAdvance(0, 1'b0, 32'h0);
        end
        checkVal("seqAddr", imemAddr, 32'hC);
        checkVal("seqCount", fetchCount, 32'd3);

        doFetch(0);
        doAdvance(0, 1'b1, 32'h100);
        checkVal("branchPc", pc, 32'h100);

        doFetch(5);
        doAdvance(2, 1'b1, 32'hFFFF_FFFC);
        doFetch(1);
        doAdvance(0, 1'b0, 32'h0);
        checkVal("wrapPc", pc, 32'h0);

        for (int i = 0; i < 25; i++) begin
            doFetch(int'($urandom_range(0, 6)));
            doAdvance(int'($urandom_range(0, 3)), 1'($urandom), $urandom & 32'hFFFF_FFFC);
        end

        // Misaligned redirect halts; later inputs must be ignored.
        doFetch(0);
        doAdvance(0, 1'b1, 32'h102);
        for (int i = 0; i < 4; i++) begin
            advance = 1'b1; imemReady = 1'b1; pcSrc = 1'b1; pcTarget = 32'h200;
            @(negedge clk);
            checkVal("haltReq", 32'(imemReq), 32'd0);
            checkVal("haltValid", 32'(instrValid), 32'd0);
            checkVal("haltPc", pc, expPc);
            checkVal("haltCount", fetchCount, expCount);
        end
        advance = 1'b0; imemReady = 1'b0;

        // Memory never answers.
        resetMain();
        checkVal("toMisClr", 32'(misalignErr), 32'd0);
        for (int i = 0; i < 255; i++) begin
            checkVal("toReq", 32'(imemReq), 32'd1);
            @(negedge clk);
        end
        checkVal("toBusErr", 32'(busErr), 32'd1);
        checkVal("toReqLow", 32'(imemReq), 32'd0);
        for (int i = 0; i < 3; i++) begin
            imemReady = 1'b1;
            @(negedge clk);
            checkVal("toHaltReq", 32'(imemReq), 32'd0);
            checkVal("toHaltValid", 32'(instrValid), 32'd0);
            checkVal("toHaltErr", 32'(busErr), 32'd1);
        end
        imemReady = 1'b0;

        // Alternate reset vector and asynchronous reset mid-request.
        resetB = 1'b0;
        @(negedge clk);
        checkVal("bReq", 32'(imemReqB), 32'd1);
        checkVal("bAddr", imemAddrB, 32'h8000_0000);
        @(negedge clk);
        #2 resetB = 1'b1;
        imemReady = 1'b1;
        #1;
        checkVal("bAsyncReq", 32'(imemReqB), 32'd0);
        checkVal("bAsyncPc", pcB, 32'h8000_0000);
        checkVal("bAsyncValid", 32'(instrValidB), 32'd0);
        @(negedge clk);
        checkVal("bDiscard", instrB, 32'h0000_0013);
        imemReady = 1'b0;
        resetB = 1'b0;
        @(negedge clk);
        checkVal("bReReq", 32'(imemReqB), 32'd1);
        checkVal("bReAddr", imemAddrB, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
